// File: rtl/rs_ff.sv
// Clocked set/reset flip-flop bank with complementary outputs.
// Each bit is independent; simultaneous set and clear follow BOTH_POLICY.
module rs_ff #(
    parameter int                 WIDTH       = 1,
    parameter logic [WIDTH-1:0]   RESET_VALUE = {WIDTH{1'b0}},
    parameter int                 BOTH_POLICY = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] nq,
    output logic [WIDTH-1:0] conflict
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_conflict;
    logic [WIDTH-1:0] w_both;
    logic [WIDTH-1:0] w_both_val;
    logic [WIDTH-1:0] w_single_val;
    logic [WIDTH-1:0] w_q_next;

    // Value taken by bits whose set and clear requests collide.
    always_comb begin
        w_both_val = r_q;
        case (BOTH_POLICY)
            0:       w_both_val = r_q;
            1:       w_both_val = {WIDTH{1'b0}};
            2:       w_both_val = {WIDTH{1'b1}};
            3:       w_both_val = ~r_q;
            default: w_both_val = r_q;
        endcase
    end

    always_comb begin
        w_both       = r & s;
        w_single_val = (r_q | s) & ~r;
        w_q_next     = (w_both & w_both_val) | (~w_both & w_single_val);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q        <= RESET_VALUE;
            r_conflict <= {WIDTH{1'b0}};
        end else begin
            r_q        <= w_q_next;
            r_conflict <= w_both;
        end
    end

    assign q        = r_q;
    assign nq       = ~r_q;
    assign conflict = r_conflict;

endmodule

// File: tb/tb_rs_ff.sv
// Self-checking bench for rs_ff: four WIDTH=4 instances, one per policy,
// plus a WIDTH=1 instance, compared against a per-bit behavioural model.
module tb_rs_ff;

    int checks = 0;
    int errors = 0;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] r;
    logic [3:0] s;

    logic [3:0] q_a  [4];
    logic [3:0] nq_a [4];
    logic [3:0] cf_a [4];
    logic       q1, nq1, cf1;

    logic [3:0] mq [4];
    logic [3:0] mc [4];
    logic       mq1, mc1;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        rs_ff #(
            .WIDTH(4),
            .RESET_VALUE(4'(g * 5)),
            .BOTH_POLICY(g)
        ) u_dut (
            .clk(clk),
            .rst_n(rst_n),
            .r(r),
            .s(s),
            .q(q_a[g]),
            .nq(nq_a[g]),
            .conflict(cf_a[g])
        );
    end

    rs_ff u_w1 (
        .clk(clk),
        .rst_n(rst_n),
        .r(r[0:0]),
        .s(s[0:0]),
        .q(q1),
        .nq(nq1),
        .conflict(cf1)
    );

    function automatic logic [3:0] rv(input int p);
        return 4'(p * 5);
    endfunction

    function void model_reset();
        for (int p = 0; p < 4; p++) begin
            mq[p] = rv(p);
            mc[p] = 4'h0;
        end
        mq1 = 1'b0;
        mc1 = 1'b0;
    endfunction

    // Per-bit truth table of an RS element under each collision policy.
    function void model_step(input logic [3:0] rr, input logic [3:0] ss);
        for (int p = 0; p < 4; p++) begin
            for (int b = 0; b < 4; b++) begin
                mc[p][b] = rr[b] && ss[b];
                if (rr[b] && ss[b]) begin
                    if (p == 1) mq[p][b] = 1'b0;
                    else if (p == 2) mq[p][b] = 1'b1;
                    else if (p == 3) mq[p][b] = !mq[p][b];
                end else if (rr[b]) begin
                    mq[p][b] = 1'b0;
                end else if (ss[b]) begin
                    mq[p][b] = 1'b1;
                end
            end
        end
        mc1 = rr[0] && ss[0];
        if (!(rr[0] && ss[0])) begin
            if (rr[0]) mq1 = 1'b0;
            else if (ss[0]) mq1 = 1'b1;
        end
    endfunction

    task automatic drive_edge(input logic [3:0] rr, input logic [3:0] ss);
        @(negedge clk);
        r = rr;
        s = ss;
        @(posedge clk);
        model_step(rr, ss);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        r = 4'h0;
        s = 4'hF;
        #2;
        rst_n = 1'b0;
        model_reset();
        for (int k = 0; k < 4; k++) begin
            #1;
            for (int p = 0; p < 4; p++) begin
                checks++;
                if (q_a[p] !== rv(p) || nq_a[p] !== ~rv(p) || cf_a[p] !== 4'h0) begin
                    errors++;
                    $display("FAIL reset p%0d q=%h nq=%h cf=%h exp q=%h", p, q_a[p], nq_a[p], cf_a[p], rv(p));
                end
            end
            checks++;
            if (q1 !== 1'b0 || nq1 !== 1'b1 || cf1 !== 1'b0) begin
                errors++;
                $display("FAIL reset_w1 q=%b nq=%b cf=%b exp q=0", q1, nq1, cf1);
            end
            @(posedge clk);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        model_step(r, s);
        #1;
        for (int p = 0; p < 4; p++) begin
            checks++;
            if (q_a[p] !== 4'hF) begin
                errors++;
                $display("FAIL release p%0d q=%h exp=f", p, q_a[p]);
            end
        end
        checks++;
        if (q1 !== 1'b1) begin
            errors++;
            $display("FAIL release_w1 q=%b exp=1", q1);
        end
    endtask

    task automatic test_sequence();
        logic [3:0] rs_tab [6] = '{4'h0, 4'h2, 4'h1, 4'h0, 4'h2, 4'h0};
        logic       exp_tab [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int k = 0; k < 6; k++) begin
            drive_edge({3'b000, rs_tab[k][1]}, {3'b000, rs_tab[k][0]});
            checks++;
            if (q1 !== exp_tab[k] || nq1 !== !exp_tab[k]) begin
                errors++;
                $display("FAIL seq%0d q=%b nq=%b exp q=%b", k, q1, nq1, exp_tab[k]);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] rr, ss;
        for (int k = 0; k < 300; k++) begin
            rr = 4'($urandom);
            ss = 4'($urandom);
            drive_edge(rr, ss);
            for (int p = 0; p < 4; p++) begin
                checks++;
                if (q_a[p] !== mq[p] || nq_a[p] !== ~mq[p] || cf_a[p] !== mc[p]) begin
                    errors++;
                    $display("FAIL rand%0d p%0d q=%h nq=%h cf=%h exp q=%h cf=%h",
                             k, p, q_a[p], nq_a[p], cf_a[p], mq[p], mc[p]);
                end
            end
            checks++;
            if (q1 !== mq1 || nq1 !== !mq1 || cf1 !== mc1) begin
                errors++;
                $display("FAIL rand%0d w1 q=%b cf=%b exp q=%b cf=%b", k, q1, cf1, mq1, mc1);
            end
        end
    endtask

    task automatic test_glitch();
        drive_edge(4'hF, 4'h0);
        drive_edge(4'h0, 4'h0);
        #1 s = 4'hF;
        #2 s = 4'h0;
        @(posedge clk);
        model_step(4'h0, 4'h0);
        #1;
        for (int p = 0; p < 4; p++) begin
            checks++;
            if (q_a[p] !== 4'h0 || q_a[p] !== mq[p]) begin
                errors++;
                $display("FAIL glitch p%0d q=%h exp=0", p, q_a[p]);
            end
        end
    endtask

    task automatic test_both();
        logic [3:0] exp1 [4] = '{4'hF, 4'h0, 4'hF, 4'h0};
        drive_edge(4'h0, 4'hF);
        drive_edge(4'hF, 4'hF);
        for (int p = 0; p < 4; p++) begin
            checks++;
            if (q_a[p] !== exp1[p] || cf_a[p] !== 4'hF || q_a[p] !== mq[p]) begin
                errors++;
                $display("FAIL both p%0d q=%h cf=%h exp q=%h cf=f", p, q_a[p], cf_a[p], exp1[p]);
            end
        end
        drive_edge(4'hF, 4'hF);
        checks++;
        if (q_a[3] !== 4'hF || q_a[3] !== mq[3]) begin
            errors++;
            $display("FAIL toggle2 q=%h exp=f", q_a[3]);
        end
        drive_edge(4'h0, 4'h0);
        for (int p = 0; p < 4; p++) begin
            checks++;
            if (cf_a[p] !== 4'h0) begin
                errors++;
                $display("FAIL both_clear p%0d cf=%h exp=0", p, cf_a[p]);
            end
        end
    endtask

    task automatic test_async();
        drive_edge(4'h0, 4'hF);
        drive_edge(4'hF, 4'hF);
        @(negedge clk);
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        for (int p = 0; p < 4; p++) begin
            checks++;
            if (q_a[p] !== rv(p) || nq_a[p] !== ~rv(p) || cf_a[p] !== 4'h0) begin
                errors++;
                $display("FAIL async p%0d q=%h nq=%h cf=%h exp q=%h", p, q_a[p], nq_a[p], cf_a[p], rv(p));
            end
        end
        checks++;
        if (q1 !== 1'b0 || nq1 !== 1'b1) begin
            errors++;
            $display("FAIL async_w1 q=%b nq=%b exp q=0", q1, nq1);
        end
        r = 4'h0;
        s = 4'h0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_width4();
        drive_edge(4'h0, 4'b0101);
        checks++;
        if (q_a[0] !== 4'b0101) begin
            errors++;
            $display("FAIL w4_set q=%b exp=0101", q_a[0]);
        end
        drive_edge(4'b0001, 4'h0);
        checks++;
        if (q_a[0] !== 4'b0100 || nq_a[0] !== 4'b1011) begin
            errors++;
            $display("FAIL w4_clr q=%b nq=%b exp q=0100 nq=1011", q_a[0], nq_a[0]);
        end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_random();
        test_glitch();
        test_both();
        test_async();
        test_width4();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
